adsr_envelope: RTL and testbench



---
 rtl/adsr_envelope_if.sv | 25 ++
 rtl/adsr_envelope.sv | 137 +++++++++++++
 tb/tb_adsr_envelope.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_if.sv
// Envelope control/data bundle between the note/voice controller (master)
// and adsr_envelope (slave).
interface adsr_envelope_if #(
  parameter int RATE_W = 16
);
  logic              gate;
  logic [7:0]        wave_in;
  logic [RATE_W-1:0] attack_period;
  logic [RATE_W-1:0] decay_period;
  logic [7:0]        sustain_level;
  logic [RATE_W-1:0] release_period;
  logic [7:0]        level;
  logic [7:0]        sample_out;
  logic              busy;

  modport master (
    output gate, wave_in, attack_period, decay_period, sustain_level, release_period,
    input  level, sample_out, busy
  );

  modport slave (
    input  gate, wave_in, attack_period, decay_period, sustain_level, release_period,
    output level, sample_out, busy
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: scales the triangle sample by a gate-driven level.
// Optional macro ADSR_RETRIGGER_EN: every rise restarts the attack from level 0.
module adsr_envelope #(
  parameter int RATE_W    = 16,
  parameter int LEVEL_MAX = 255
) (
  input  logic           clk,
  input  logic           reset,
  adsr_envelope_if.slave env
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [7:0] LVL_TOP = 8'(LEVEL_MAX);

`ifdef ADSR_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic [2:0]        state, state_nxt;
  logic [7:0]        level_q, level_nxt;
  logic [7:0]        sample_q;
  logic              busy_q;
  logic              gate_d;
  logic              rise, fall;
  logic [RATE_W-1:0] cnt, cnt_nxt;
  logic [RATE_W-1:0] period, p_last;
  logic              stepping, step;
  logic [8:0]        lvl_p1;
  logic [16:0]       prod;

  assign rise = env.gate & ~gate_d;
  assign fall = ~env.gate & gate_d;

  // Step timer: live period of the active stage, P=0 behaves as P=1.
  always_comb begin
    period   = '0;
    stepping = 1'b0;
    case (state)
      ST_ATTACK:  begin period = env.attack_period;  stepping = 1'b1; end
      ST_DECAY:   begin period = env.decay_period;   stepping = 1'b1; end
      ST_RELEASE: begin period = env.release_period; stepping = 1'b1; end
      default:    begin period = '0;                 stepping = 1'b0; end
    endcase
    p_last = (period == '0) ? '0 : period - RATE_W'(1);
    // >= so a period shortened below the running count fires on the next compare
    step   = stepping && (cnt >= p_last);
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level_q;
    case (state)
      ST_IDLE: begin
        level_nxt = '0;
        if (rise) state_nxt = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (fall) begin
          state_nxt = ST_RELEASE;
        end else if (level_q == LVL_TOP) begin
          // legato re-entry at full scale: nothing left to climb
          state_nxt = ST_DECAY;
        end else if (step) begin
          level_nxt = level_q + 8'd1;
          if (level_q + 8'd1 == LVL_TOP) state_nxt = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (fall) begin
          state_nxt = ST_RELEASE;
        end else if (level_q <= env.sustain_level) begin
          state_nxt = ST_SUSTAIN;
          level_nxt = env.sustain_level;
        end else if (step) begin
          level_nxt = level_q - 8'd1;
        end
      end
      ST_SUSTAIN: begin
        level_nxt = env.sustain_level;
        if (fall) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rise) begin
          state_nxt = ST_ATTACK;
          if (RETRIG) level_nxt = '0;
        end else if (level_q == '0) begin
          state_nxt = ST_IDLE;
        end else if (step) begin
          level_nxt = level_q - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        level_nxt = '0;
      end
    endcase
  end

  always_comb begin
    if (state_nxt != state || !stepping || step) cnt_nxt = '0;
    else                                         cnt_nxt = cnt + RATE_W'(1);
  end

  // (level+1) keeps full scale exact: 255*256>>8 == 255, while level 0 still yields 0.
  assign lvl_p1 = {1'b0, level_q} + 9'd1;
  assign prod   = {9'd0, env.wave_in} * {8'd0, lvl_p1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      level_q  <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      cnt      <= '0;
      gate_d   <= 1'b0;
    end else begin
      state    <= state_nxt;
      level_q  <= level_nxt;
      sample_q <= prod[15:8];
      busy_q   <= (state_nxt != ST_IDLE);
      cnt      <= cnt_nxt;
      gate_d   <= env.gate;
    end
  end

  assign env.level      = level_q;
  assign env.sample_out = sample_q;
  assign env.busy       = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: per-cycle vector table plus multi-cycle
// envelope sequences (full ADSR, legato/retrigger, full-scale, reset abort).
module tb_adsr_envelope;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  adsr_envelope_if #(.RATE_W(16)) env ();

  adsr_envelope #(.RATE_W(16), .LEVEL_MAX(255)) dut (
    .clk   (clk),
    .reset (reset),
    .env   (env)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       gate;
    logic [7:0] e_level;
    logic [7:0] e_sample;
    logic       e_busy;
  } vec_t;

  vec_t vecs [0:21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_level(input logic [7:0] tgt, input string name);
    int n = 0;
    while (env.level !== tgt && n < 600) begin
      tick();
      n++;
    end
    check(name, int'(env.level), int'(tgt));
  endtask

  task automatic set_vec(input int i, input logic r, input logic g,
                         input logic [7:0] l, input logic [7:0] s, input logic b);
    vecs[i].rst = r; vecs[i].gate = g;
    vecs[i].e_level = l; vecs[i].e_sample = s; vecs[i].e_busy = b;
  endtask

  initial begin
    // wave_in=200, attack_period=0 (acts as 1), release_period=1
    set_vec(0, 1, 0, 0, 0, 0);
    set_vec(1, 1, 0, 0, 0, 0);
    for (int i = 2; i < 10; i++) set_vec(i, 0, 0, 0, 0, 0);
    set_vec(10, 0, 1, 0, 0, 1);   // rise -> ATTACK
    set_vec(11, 0, 1, 1, 0, 1);
    set_vec(12, 0, 1, 2, 1, 1);
    set_vec(13, 0, 1, 3, 2, 1);
    set_vec(14, 0, 1, 4, 3, 1);
    set_vec(15, 0, 0, 4, 3, 1);   // fall -> RELEASE keeps level
    set_vec(16, 0, 0, 3, 3, 1);
    set_vec(17, 0, 0, 2, 3, 1);
    set_vec(18, 0, 0, 1, 2, 1);
    set_vec(19, 0, 0, 0, 1, 1);
    set_vec(20, 0, 0, 0, 0, 0);   // level 0 -> IDLE
    set_vec(21, 0, 0, 0, 0, 0);

    reset = 1'b1;
    env.gate = 1'b0; env.wave_in = 8'd200;
    env.attack_period = 16'd0; env.decay_period = 16'd2;
    env.sustain_level = 8'd128; env.release_period = 16'd1;

    for (int i = 0; i < 22; i++) begin
      reset    = vecs[i].rst;
      env.gate = vecs[i].gate;
      tick();
      check($sformatf("vec%0d_level", i),  int'(env.level),      int'(vecs[i].e_level));
      check($sformatf("vec%0d_sample", i), int'(env.sample_out), int'(vecs[i].e_sample));
      check($sformatf("vec%0d_busy", i),   int'(env.busy),       int'(vecs[i].e_busy));
    end

    // Full ADSR cycle
    reset = 1'b1; tick(); reset = 1'b0;
    env.attack_period = 16'd1; env.decay_period = 16'd2;
    env.sustain_level = 8'd128; env.release_period = 16'd4; env.wave_in = 8'd200;
    env.gate = 1'b1;
    tick();
    check("attack_entry_busy", int'(env.busy), 1);
    check("attack_entry_level", int'(env.level), 0);
    repeat (254) tick();
    check("attack_254", int'(env.level), 254);
    tick();
    check("attack_peak", int'(env.level), 255);
    repeat (253) tick();
    check("decay_253", int'(env.level), 129);
    tick();
    check("decay_sustain", int'(env.level), 128);
    repeat (5) tick();
    check("sustain_hold", int'(env.level), 128);
    check("sustain_sample", int'(env.sample_out), 100);
    env.sustain_level = 8'd64;
    tick();
    check("sustain_follow", int'(env.level), 64);
    env.gate = 1'b0;
    tick();
    check("release_entry", int'(env.level), 64);
    repeat (255) tick();
    check("release_255", int'(env.level), 1);
    check("release_busy", int'(env.busy), 1);
    tick();
    check("release_256", int'(env.level), 0);
    tick();
    check("idle_busy", int'(env.busy), 0);
    check("idle_level", int'(env.level), 0);

    // Re-raise during release: legato vs retrigger
    env.attack_period = 16'd1; env.release_period = 16'd1;
    env.gate = 1'b1;
    wait_level(8'd100, "reach_100");
    env.gate = 1'b0;
    tick();
    check("rel_from_100", int'(env.level), 100);
    wait_level(8'd50, "reach_50");
    env.gate = 1'b1;
    tick();
`ifdef ADSR_RETRIGGER_EN
    check("retrig_0", int'(env.level), 0);
    tick(); check("retrig_1", int'(env.level), 1);
    tick(); check("retrig_2", int'(env.level), 2);
`else
    check("legato_50", int'(env.level), 50);
    tick(); check("legato_51", int'(env.level), 51);
    tick(); check("legato_52", int'(env.level), 52);
`endif

    // Period 0 attack, drop gate at 10
    reset = 1'b1; env.gate = 1'b0; tick(); reset = 1'b0;
    env.attack_period = 16'd0; env.release_period = 16'd3;
    env.gate = 1'b1;
    wait_level(8'd10, "p0_reach_10");
    env.gate = 1'b0;
    tick();
    check("p0_release_10", int'(env.level), 10);
    repeat (3) tick();
    check("p0_release_9", int'(env.level), 9);

    // Full scale, then reset mid-DECAY with gate held high through reset
    reset = 1'b1; tick(); reset = 1'b0;
    env.attack_period = 16'd1; env.decay_period = 16'd100;
    env.sustain_level = 8'd10; env.wave_in = 8'd255;
    env.gate = 1'b1;
    wait_level(8'd255, "reach_255");
    tick();
    check("full_scale_sample", int'(env.sample_out), 255);
    reset = 1'b1;
    tick();
    check("rst_level", int'(env.level), 0);
    check("rst_sample", int'(env.sample_out), 0);
    check("rst_busy", int'(env.busy), 0);
    reset = 1'b0;
    tick();
    check("gate_held_rise", int'(env.busy), 1);
    check("zero_level_sample", int'(env.sample_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
